// File: rtl/vector_sequencer_pkg.sv
// Shared types and defaults for vector_sequencer: FSM state encoding,
// default truth table (y = ~b&~c | a&~b) and default settle time.
package vector_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_EXPECTED      = 8'h31;
  localparam int         DEFAULT_SETTLE_CYCLES = 1;

endpackage

// File: rtl/vector_sequencer.sv
// In-system exhaustive checker for a small N_IN-input combinational block.
// Define VECTOR_SEQUENCER_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int                   N_IN          = 3,
  parameter logic [(2**N_IN)-1:0] EXPECTED      = DEFAULT_EXPECTED,
  parameter int                   SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  localparam int                WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]   LAST_IDX  = {N_IN{1'b1}};

  state_t            r_state;
  state_t            w_next;
  logic [N_IN-1:0]   r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic [N_IN:0]     r_err;
  logic [N_IN-1:0]   r_ff_idx;
  logic              r_ff_vld;

  logic w_mismatch;
  logic w_stop;
  logic w_last_vec;
  logic w_wait_done;

  assign w_mismatch  = (dut_out != EXPECTED[r_idx]);
  assign w_last_vec  = (r_idx == LAST_IDX);
  assign w_wait_done = (r_wait == LAST_WAIT);

`ifdef VECTOR_SEQUENCER_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // State register plus index, wait counter and result bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_wait   <= '0;
      r_err    <= '0;
      r_ff_idx <= '0;
      r_ff_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_idx    <= '0;
            r_wait   <= '0;
            r_err    <= '0;
            r_ff_idx <= '0;
            r_ff_vld <= 1'b0;
          end
        end
        APPLY: begin
          if (!w_wait_done) r_wait <= r_wait + WAIT_W'(1);
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + (N_IN+1)'(1);
            if (!r_ff_vld) begin
              r_ff_idx <= r_idx;
              r_ff_vld <= 1'b1;
            end
          end
          if (!(w_stop || w_last_vec)) begin
            r_idx  <= r_idx + N_IN'(1);
            r_wait <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = APPLY;
      APPLY:   if (w_wait_done) w_next = CHECK;
      CHECK:   w_next = (w_stop || w_last_vec) ? DONE : APPLY;
      DONE:    if (start) w_next = APPLY;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == APPLY) || (r_state == CHECK);
    done = (r_state == DONE);
    pass = (r_state == DONE) && (r_err == '0);
  end

  assign dut_in           = r_idx;
  assign err_count        = r_err;
  assign first_fail_idx   = r_ff_idx;
  assign first_fail_valid = r_ff_vld;

endmodule
